pcm_mm_arbiter: RTL and testbench

Parametrised N-port arbiter between the CPU cores and the single-port on-chip PCM memory slave (pcm_mem_mm_*). It is the generalised successor of the fixed four-CPU memory-mapped front end. It adds configurable port count, widths and memory read latency, fair round-robin grant, request/ready handshaking, latched transactions and out-of-range address error reporting.

---
 rtl/pcm_mm_arbiter.sv | 145 ++++++++++++++
 tb/tb_pcm_mm_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_mm_arbiter.sv
// Round-robin N-port arbiter in front of the single-port PCM memory slave.
// Each grant latches one CPU transaction and runs it through ISSUE/WAIT/RESP.
module pcm_mm_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int MEM_ADDR_W = 11,
    parameter int RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          cpu_req,
    input  logic [NUM_PORTS-1:0]          cpu_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   cpu_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   cpu_wdata,
    output logic [NUM_PORTS-1:0]          cpu_ready,
    output logic [NUM_PORTS-1:0]          cpu_err,
    output logic [NUM_PORTS*DATA_W-1:0]   cpu_rdata,
    output logic                          busy,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
    output logic [MEM_ADDR_W-1:0]         pcm_mem_mm_address,
    output logic                          pcm_mem_mm_chipselect,
    output logic                          pcm_mem_mm_clken,
    output logic                          pcm_mem_mm_write,
    input  logic [DATA_W-1:0]             pcm_mem_mm_readdata,
    output logic [DATA_W-1:0]             pcm_mem_mm_writedata,
    output logic [DATA_W/8-1:0]           pcm_mem_mm_byteenable
);
    localparam int ID_W  = $clog2(NUM_PORTS);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   last_grant;
    logic              write_p0;
    logic              err_p0;
    logic [CNT_W-1:0]  cnt;

    logic              found;
    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic [ID_W-1:0]   resp_id;
    logic              resp_err;

    assign pcm_mem_mm_clken      = 1'b1;
    assign pcm_mem_mm_byteenable = '1;

    // First requester strictly after the last served port, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = last_grant;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_PORTS);
            if (!found && cpu_req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_write = cpu_write[sel];
    assign sel_addr  = cpu_addr[sel*ADDR_W +: ADDR_W];
    assign sel_wdata = cpu_wdata[sel*DATA_W +: DATA_W];

    if (MEM_ADDR_W < ADDR_W) begin : g_oor
        assign sel_oor = |sel_addr[ADDR_W-1:MEM_ADDR_W];
    end else begin : g_no_oor
        assign sel_oor = 1'b0;
    end

    // Error responses leave IDLE straight for RESP, before grant_id is loaded.
    assign resp_id  = (state == IDLE) ? sel : grant_id;
    assign resp_err = (state == IDLE) ? sel_oor : err_p0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = sel_oor ? RESP : ISSUE;
            ISSUE:   state_nx = write_p0 ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(RD_LAT)) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            last_grant            <= ID_W'(NUM_PORTS - 1);
            grant_id              <= '0;
            write_p0              <= 1'b0;
            err_p0                <= 1'b0;
            cnt                   <= '0;
            cpu_ready             <= '0;
            cpu_err               <= '0;
            cpu_rdata             <= '0;
            busy                  <= 1'b0;
            pcm_mem_mm_chipselect <= 1'b0;
            pcm_mem_mm_write      <= 1'b0;
            pcm_mem_mm_address    <= '0;
            pcm_mem_mm_writedata  <= '0;
        end else begin
            state                 <= state_nx;
            busy                  <= (state_nx != IDLE);
            pcm_mem_mm_chipselect <= (state_nx == ISSUE);
            pcm_mem_mm_write      <= (state_nx == ISSUE) && sel_write;
            cpu_ready             <= '0;
            cpu_err               <= '0;

            if (state == IDLE && found) begin
                grant_id             <= sel;
                write_p0             <= sel_write;
                err_p0               <= sel_oor;
                pcm_mem_mm_address   <= sel_addr[MEM_ADDR_W-1:0];
                pcm_mem_mm_writedata <= sel_wdata;
            end

            // Count starts at 1 in the first WAIT cycle; capture on the last.
            if (state == ISSUE) begin
                cnt <= CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end

            if (state == WAIT && cnt == CNT_W'(RD_LAT)) begin
                cpu_rdata[grant_id*DATA_W +: DATA_W] <= pcm_mem_mm_readdata;
            end

            if (state_nx == RESP) begin
                cpu_ready <= NUM_PORTS'(1) << resp_id;
                cpu_err   <= resp_err ? (NUM_PORTS'(1) << resp_id) : '0;
            end

            if (state == RESP) begin
                last_grant <= grant_id;
            end
        end
    end
endmodule

// File: tb/tb_pcm_mm_arbiter.sv
// Scoreboard bench: stimulus queues expected responses, a monitor checks each
// cpu_ready pulse against them; two instances cover default and 8-port/RD_LAT=3.
module tb_pcm_mm_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance: 4 ports, 16-bit data, RD_LAT=1
    logic [3:0]  req, wr, ready, err;
    logic [79:0] addr;
    logic [63:0] wdata, rdata;
    logic        busy, m_cs, m_clken, m_wr;
    logic [1:0]  gid, m_be;
    logic [10:0] m_addr;
    logic [15:0] m_rd, m_wd;

    pcm_mm_arbiter #(.NUM_PORTS(4), .ADDR_W(20), .DATA_W(16), .MEM_ADDR_W(11), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .cpu_req(req), .cpu_write(wr), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_ready(ready), .cpu_err(err), .cpu_rdata(rdata),
        .busy(busy), .grant_id(gid), .pcm_mem_mm_address(m_addr),
        .pcm_mem_mm_chipselect(m_cs), .pcm_mem_mm_clken(m_clken),
        .pcm_mem_mm_write(m_wr), .pcm_mem_mm_readdata(m_rd),
        .pcm_mem_mm_writedata(m_wd), .pcm_mem_mm_byteenable(m_be));

    // Wide instance: 8 ports, 32-bit data, RD_LAT=3
    logic [7:0]   req8, wr8, ready8, err8;
    logic [159:0] addr8;
    logic [255:0] wdata8, rdata8;
    logic         busy8, m8_cs, m8_clken, m8_wr;
    logic [2:0]   gid8;
    logic [3:0]   m8_be;
    logic [10:0]  m8_addr;
    logic [31:0]  m8_rd, m8_wd;

    pcm_mm_arbiter #(.NUM_PORTS(8), .ADDR_W(20), .DATA_W(32), .MEM_ADDR_W(11), .RD_LAT(3)) dut8 (
        .clk(clk), .reset(reset), .cpu_req(req8), .cpu_write(wr8), .cpu_addr(addr8),
        .cpu_wdata(wdata8), .cpu_ready(ready8), .cpu_err(err8), .cpu_rdata(rdata8),
        .busy(busy8), .grant_id(gid8), .pcm_mem_mm_address(m8_addr),
        .pcm_mem_mm_chipselect(m8_cs), .pcm_mem_mm_clken(m8_clken),
        .pcm_mem_mm_write(m8_wr), .pcm_mem_mm_readdata(m8_rd),
        .pcm_mem_mm_writedata(m8_wd), .pcm_mem_mm_byteenable(m8_be));

    // Memory models; non-read cycles return junk to expose mistimed captures
    logic [15:0] mem  [0:2047];
    logic [31:0] mem8 [0:2047];
    logic [31:0] r1, r2, r3;
    int          cs_cnt = 0;
    logic [10:0] cs_addr = '0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        m_rd = 16'hDEAD;
        forever begin
            @(posedge clk);
            if (m_cs && m_wr) mem[m_addr] <= m_wd;
            m_rd <= (m_cs && !m_wr) ? mem[m_addr] : 16'hDEAD;
            if (m_cs) begin
                cs_cnt  <= cs_cnt + 1;
                cs_addr <= m_addr;
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem8[i] = 32'h5A00_0000 | 32'(i);
        r1 = 32'hDEADBEEF; r2 = 32'hDEADBEEF; r3 = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (m8_cs && m8_wr) mem8[m8_addr] <= m8_wd;
            r1 <= (m8_cs && !m8_wr) ? mem8[m8_addr] : 32'hDEADBEEF;
            r2 <= r1;
            r3 <= r2;
        end
    end
    assign m8_rd = r3;

    typedef struct {
        int          port;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q8[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic exp0(input int p, input bit e, input bit c, input logic [31:0] d, input int cy);
        q0.push_back('{port: p, err: e, chk: c, rdata: d, cyc: cy});
    endtask

    task automatic req_port(input int p, input bit w, input logic [19:0] a, input logic [15:0] d);
        req[p] = 1'b1;
        wr[p] = w;
        addr[p*20 +: 20] = a;
        wdata[p*16 +: 16] = d;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready[p]) begin
                req[p] = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL timeout_port%0d actual=no_ready required=ready", p);
        req[p] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every ready pulse must match the head of its scoreboard queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready != '0) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ready actual=%b required=0000", ready);
                end else begin
                    e = q0.pop_front();
                    check("ready_port", 64'(ready), 64'(1) << e.port);
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("err", 64'(err), e.err ? (64'(1) << e.port) : 64'(0));
                    check("grant_id", 64'(gid), 64'(e.port));
                    if (e.chk) check("rdata", 64'(rdata[e.port*16 +: 16]), 64'(e.rdata[15:0]));
                end
            end else if (err != '0) begin
                checks++; failures++;
                $display("FAIL err_without_ready actual=%b required=0000", err);
            end
            if (ready8 != '0) begin
                if (q8.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ready8 actual=%b required=00000000", ready8);
                end else begin
                    e = q8.pop_front();
                    check("ready8_port", 64'(ready8), 64'(1) << e.port);
                    check("ready8_cycle", 64'(cyc), 64'(e.cyc));
                    check("err8", 64'(err8), e.err ? (64'(1) << e.port) : 64'(0));
                    check("grant_id8", 64'(gid8), 64'(e.port));
                    if (e.chk) check("rdata8", 64'(rdata8[e.port*32 +: 32]), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int n_cs;
        reset = 1'b1;
        req = '0; wr = '0; addr = '0; wdata = '0;
        req8 = '0; wr8 = '0; addr8 = '0; wdata8 = '0;
        repeat (3) @(negedge clk);

        check("rst_ready", 64'(ready), 0);
        check("rst_err", 64'(err), 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_gid", 64'(gid), 0);
        check("rst_cs", 64'(m_cs), 0);
        check("rst_wr", 64'(m_wr), 0);
        check("rst_addr", 64'(m_addr), 0);
        check("rst_wdata", 64'(m_wd), 0);
        check("clken", 64'(m_clken), 1);
        check("byteenable", 64'(m_be), 64'h3);
        reset = 1'b0;

        // Port 2 writes 0xBEEF to 0x005, then reads it back
        c = cyc;
        exp0(2, 1'b0, 1'b0, 32'h0, c + 2);
        req_port(2, 1'b1, 20'h00005, 16'hBEEF);
        @(negedge clk);
        check("mem_005", 64'(mem[5]), 64'hBEEF);
        c = cyc;
        exp0(2, 1'b0, 1'b1, 32'hBEEF, c + 3);
        req_port(2, 1'b0, 20'h00005, 16'h0);
        @(negedge clk);

        // All four ports read together from reset: grants 0,1,2,3
        do_reset();
        c = cyc;
        exp0(0, 1'b0, 1'b1, 32'hA4A5, c + 3);
        exp0(1, 1'b0, 1'b1, 32'hA4A4, c + 7);
        exp0(2, 1'b0, 1'b1, 32'hA4A7, c + 11);
        exp0(3, 1'b0, 1'b1, 32'hA4A6, c + 15);
        fork
            req_port(0, 1'b0, 20'h00100, 16'h0);
            req_port(1, 1'b0, 20'h00101, 16'h0);
            req_port(2, 1'b0, 20'h00102, 16'h0);
            req_port(3, 1'b0, 20'h00103, 16'h0);
        join
        @(negedge clk);

        // Only ports 1 and 3 after last grant 3: order 1,3
        c = cyc;
        exp0(1, 1'b0, 1'b1, 32'hA4A4, c + 3);
        exp0(3, 1'b0, 1'b1, 32'hA4A6, c + 7);
        fork
            req_port(3, 1'b0, 20'h00103, 16'h0);
            req_port(1, 1'b0, 20'h00101, 16'h0);
        join
        @(negedge clk);

        // Out-of-range read from port 1: error one cycle after IDLE, no access
        n_cs = cs_cnt;
        c = cyc;
        exp0(1, 1'b1, 1'b0, 32'h0, c + 1);
        req_port(1, 1'b0, 20'h00800, 16'h0);
        @(negedge clk);
        check("oor_no_cs", 64'(cs_cnt), 64'(n_cs));
        check("oor_rdata_kept", 64'(rdata[16 +: 16]), 64'hA4A4);

        // Port 0 write; addr and wdata change during ISSUE must not leak
        n_cs = cs_cnt;
        c = cyc;
        exp0(0, 1'b0, 1'b0, 32'h0, c + 2);
        fork
            req_port(0, 1'b1, 20'h00010, 16'h1234);
            begin
                @(negedge clk);
                addr[0 +: 20]  = 20'h00020;
                wdata[0 +: 16] = 16'hFFFF;
            end
        join
        @(negedge clk);
        check("latch_cs_count", 64'(cs_cnt), 64'(n_cs + 1));
        check("latch_cs_addr", 64'(cs_addr), 64'h010);
        check("latch_mem_010", 64'(mem[11'h010]), 64'h1234);
        check("latch_mem_020", 64'(mem[11'h020]), 64'hA585);

        // Reset during WAIT of a port 2 read: dropped, no ready pulse
        c = cyc;
        wr[2] = 1'b0;
        addr[40 +: 20] = 20'h00005;
        req[2] = 1'b1;
        @(negedge clk);
        check("issue_gid", 64'(gid), 2);
        check("issue_cs", 64'(m_cs), 1);
        @(negedge clk);
        check("wait_busy", 64'(busy), 1);
        reset = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        check("wrst_ready", 64'(ready), 0);
        check("wrst_busy", 64'(busy), 0);
        check("wrst_gid", 64'(gid), 0);
        check("wrst_rdata", rdata, 0);
        check("wrst_cs", 64'(m_cs), 0);
        check("wrst_addr", 64'(m_addr), 0);
        check("wrst_wdata", 64'(m_wd), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Priority restored to port 0 after reset
        c = cyc;
        exp0(0, 1'b0, 1'b1, 32'h1234, c + 3);
        exp0(3, 1'b0, 1'b1, 32'hA585, c + 7);
        fork
            req_port(3, 1'b0, 20'h00020, 16'h0);
            req_port(0, 1'b0, 20'h00010, 16'h0);
        join
        @(negedge clk);

        // Wide instance: port 7 read with RD_LAT=3
        c = cyc;
        q8.push_back('{port: 7, err: 1'b0, chk: 1'b1, rdata: 32'h5A0000AB, cyc: c + 5});
        wr8[7] = 1'b0;
        addr8[140 +: 20] = 20'h000AB;
        req8[7] = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                if (ready8[7]) seen = 1'b1;
            end
            req8[7] = 1'b0;
            if (!seen) begin
                checks++; failures++;
                $display("FAIL timeout_port8_7 actual=no_ready required=ready");
            end
        end
        check("byteenable8", 64'(m8_be), 64'hF);
        check("clken8", 64'(m8_clken), 1);
        @(negedge clk);

        check("sb_empty", 64'(q0.size()), 0);
        check("sb8_empty", 64'(q8.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
